// File: rtl/pixel_shifter_pkg.sv
// pixel_shifter_pkg: shared widths and the pixel selection helper for pixel_shifter.
//   PIX_W        bits per pixel
//   PIX_PER_WORD pixels packed in one tile word
//   WORD_W       tile word width
//   IDX_W        width of the pixel index within a word
package pixel_shifter_pkg;

    localparam int PIX_W        = 4;
    localparam int PIX_PER_WORD = 8;
    localparam int WORD_W       = 32;
    localparam int IDX_W        = 3;

    // Pixel k lives at bits [4k+3:4k]; a flipped word is read from the top
    // nibble down, and 7-idx is simply ~idx for a 3-bit index.
    function automatic logic [PIX_W-1:0] pick(
        input logic [WORD_W-1:0] w,
        input logic [IDX_W-1:0]  idx,
        input logic              flp
    );
        logic [IDX_W-1:0]  k;
        logic [WORD_W-1:0] s;
        k = flp ? ~idx : idx;
        s = w >> {k, 2'b00};
        return s[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/pixel_shifter_slot.sv
// pixel_shifter_slot: one word-wide storage slot (data, flip, full flag).
//   ck, reset     clock and synchronous active-high reset (clears full only)
//   load          capture d / d_flip and mark the slot full
//   clear         mark the slot empty
//   d, d_flip     incoming word and its flip bit
//   data, flip    stored word and flip bit
//   full          slot holds a word
module pixel_shifter_slot
    import pixel_shifter_pkg::*;
(
    input  logic              ck,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [WORD_W-1:0] d,
    input  logic              d_flip,
    output logic [WORD_W-1:0] data,
    output logic              flip,
    output logic              full
);

    always_ff @(posedge ck) begin
        if (load) begin
            data <= d;
            flip <= d_flip;
        end
    end

    always_ff @(posedge ck) begin
        full <= reset ? 1'b0 : load ? 1'b1 : clear ? 1'b0 : full;
    end

endmodule

// File: rtl/pixel_shifter.sv
// pixel_shifter: two-slot tile word buffer that serialises 4-bit pixels, one per CE cycle.
//   ck           clock, all state on rising edge
//   reset        synchronous active-high reset
//   ce           pixel clock enable
//   load_valid   upstream offers load_data / flip
//   load_ready   holding buffer empty, word can be accepted
//   load_data    eight 4-bit pixels, pixel k at [4k+3:4k]
//   flip         horizontal flip, captured with the word
//   pix_out      registered pixel
//   pix_valid    pix_out carries a real pixel
//   underrun     one-cycle pulse when a pixel was demanded with no data
module pixel_shifter
    import pixel_shifter_pkg::*;
(
    input  logic              ck,
    input  logic              reset,
    input  logic              ce,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [WORD_W-1:0] load_data,
    input  logic              flip,
    output logic [PIX_W-1:0]  pix_out,
    output logic              pix_valid,
    output logic              underrun
);

    logic [WORD_W-1:0] hb_data;
    logic [WORD_W-1:0] sr_data;
    logic              hb_flip;
    logic              hb_full;
    logic              sr_flip;
    logic              sr_full;
    logic              armed;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              fill;
    logic              reload;
    logic              last;

    assign load_ready = ~hb_full;
    assign accept     = load_valid & load_ready & ~reset;
    assign last       = idx == IDX_W'(PIX_PER_WORD - 1);
    // Idle shift stage pulls from HB without waiting for CE.
    assign fill       = hb_full & ~sr_full;
    // Last pixel of a word goes out while the next word moves in: no gap.
    assign reload     = ce & sr_full & last & hb_full;

    pixel_shifter_slot u_hb (
        .ck     (ck),
        .reset  (reset),
        .load   (accept),
        .clear  (fill | reload),
        .d      (load_data),
        .d_flip (flip),
        .data   (hb_data),
        .flip   (hb_flip),
        .full   (hb_full)
    );

    always_ff @(posedge ck) begin
        if (fill | reload) begin
            sr_data <= hb_data;
            sr_flip <= hb_flip;
        end
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            sr_full   <= 1'b0;
            idx       <= '0;
            armed     <= 1'b0;
            pix_out   <= '0;
            pix_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= ce & ~sr_full & armed;
            if (accept)
                armed <= 1'b1;
            if (ce) begin
                pix_out   <= sr_full ? pick(sr_data, idx, sr_flip) : '0;
                pix_valid <= sr_full;
            end
            if (fill | reload) begin
                sr_full <= 1'b1;
                idx     <= '0;
            end else if (ce & sr_full) begin
                idx <= idx + 1'b1;
                if (last)
                    sr_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_shifter.sv
// tb_pixel_shifter: table-driven and sequence checks of pixel_shifter against a pixel scoreboard.
module tb_pixel_shifter;
    import pixel_shifter_pkg::*;

    logic        ck = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] load_data = '0;
    logic        flip = 1'b0;
    logic [3:0]  pix_out;
    logic        pix_valid;
    logic        underrun;

    pixel_shifter dut (
        .ck         (ck),
        .reset      (reset),
        .ce         (ce),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .flip       (flip),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid),
        .underrun   (underrun)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [31:0] data;
        logic        flp;
        int          per;
        logic [31:0] exp;
    } vec_t;

    vec_t       vecs [5];
    logic [3:0] q [$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         ce_per = 0;
    int         acc_cyc = 0;
    int         first_cyc = -1;
    int         gaps = 0;
    int         npix = 0;
    bit         streaming = 0;
    logic [3:0] last_out = '0;
    logic       last_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        logic       ce_was;
        logic       rst_was;
        logic [3:0] e;
        if (ce_per != 0)
            ce = (cyc % ce_per) == 0;
        ce_was  = ce;
        rst_was = reset;
        @(posedge ck);
        #1;
        cyc++;
        if (!rst_was) begin
            if (ce_was) begin
                if (pix_valid) begin
                    streaming = 1;
                    npix++;
                    if (first_cyc < 0)
                        first_cyc = cyc;
                    if (q.size() == 0) begin
                        check("extra_pixel", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        check("pixel", {28'd0, pix_out}, {28'd0, e});
                    end
                end else if (streaming && q.size() != 0) begin
                    gaps++;
                end
            end else begin
                check("hold_out", {27'd0, pix_valid, pix_out}, {27'd0, last_valid, last_out});
                check("hold_underrun", {31'd0, underrun}, 32'd0);
            end
        end
        last_out   = pix_out;
        last_valid = pix_valid;
    endtask

    task automatic send(input logic [31:0] d, input logic f, input logic [31:0] e);
        load_valid = 1'b1;
        load_data  = d;
        flip       = f;
        for (int n = 0; n < 40; n++) begin
            if (load_ready === 1'b1) begin
                for (int k = 0; k < 8; k++)
                    q.push_back(e[4*k +: 4]);
                tick();
                acc_cyc    = cyc;
                load_valid = 1'b0;
                flip       = ~f;
                return;
            end
            tick();
        end
        load_valid = 1'b0;
        check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && q.size() != 0; n++)
            tick();
        check("drain_left", q.size(), 32'd0);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        ce_per     = 0;
        ce         = 1'b1;
        load_valid = 1'b1;
        load_data  = 32'hdeadbeef;
        tick();
        reset      = 1'b0;
        load_valid = 1'b0;
        q.delete();
        streaming = 0;
        gaps      = 0;
        npix      = 0;
        first_cyc = -1;
        check("rst_valid", {31'd0, pix_valid}, 32'd0);
        check("rst_out", {28'd0, pix_out}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_ready", {31'd0, load_ready}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{32'h76543210, 1'b0, 1, 32'h76543210};
        vecs[1] = '{32'h76543210, 1'b1, 1, 32'h01234567};
        vecs[2] = '{32'h76543210, 1'b0, 3, 32'h76543210};
        vecs[3] = '{32'hfedcba98, 1'b1, 2, 32'h89abcdef};
        vecs[4] = '{32'h0f0f00ff, 1'b0, 1, 32'h0f0f00ff};

        for (int i = 0; i < 5; i++) begin
            do_reset();
            ce_per = vecs[i].per;
            send(vecs[i].data, vecs[i].flp, vecs[i].exp);
            drain();
            check("npix", npix, 32'd8);
            if (vecs[i].per == 1)
                check("latency", first_cyc - acc_cyc, 32'd2);
            repeat (3) tick();
            check("tail_valid", {31'd0, pix_valid}, 32'd0);
        end

        do_reset();
        ce_per = 1;
        send(32'h11111111, 1'b0, 32'h11111111);
        check("ready_hb_full_a", {31'd0, load_ready}, 32'd0);
        send(32'h22222222, 1'b0, 32'h22222222);
        check("ready_hb_full_b", {31'd0, load_ready}, 32'd0);
        drain();
        check("stream_npix", npix, 32'd16);
        check("stream_gaps", gaps, 32'd0);

        do_reset();
        ce = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("early_underrun", {31'd0, underrun}, 32'd0);
        end
        ce = 1'b0;
        send(32'h76543210, 1'b0, 32'h76543210);
        tick();
        ce = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("run_valid", {31'd0, pix_valid}, {31'd0, i <= 8});
            check("run_underrun", {31'd0, underrun}, {31'd0, i >= 9});
        end
        ce = 1'b0;
        tick();
        check("underrun_idle", {31'd0, underrun}, 32'd0);

        do_reset();
        ce_per = 1;
        send(32'h76543210, 1'b0, 32'h76543210);
        send(32'hfedcba98, 1'b0, 32'hfedcba98);
        tick();
        tick();
        check("mid_ready", {31'd0, load_ready}, 32'd0);
        check("mid_npix", npix, 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
        check("mid_rst_valid", {31'd0, pix_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, load_ready}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("post_rst_underrun", {31'd0, underrun}, 32'd0);
        end
        check("post_rst_valid", {31'd0, pix_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
